// File: rtl/low_freq_fir.sv
// Stereo low-band FIR engine: multiply-accumulates one sample burst against a
// synchronous coefficient ROM and emits one saturated result pair per burst.
module low_freq_fir #(
    parameter int unsigned TAPS  = 1021,
    parameter int unsigned ACC_W = 42
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sequencing,
    input  logic [15:0] lft_in,
    input  logic [15:0] rght_in,
    output logic [9:0]  coeff_addr,
    input  logic [15:0] coeff,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic        valid,
    output logic        tap_err
);

    localparam int unsigned CNT_W = $clog2(TAPS + 1);
    localparam int unsigned ADR_W = 10;
    localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] TAPS_M1 = CNT_W'(TAPS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic                    seq_q;
    logic [CNT_W-1:0]        cnt;
    logic                    overrun;
    logic                    mac_en_d;
    logic signed [15:0]      smpl_d_l;
    logic signed [15:0]      smpl_d_r;
    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;

    logic start;
    logic take;
    logic drop;
    logic finish;

    logic signed [15:0] coeff_s;
    logic signed [31:0] prod_l;
    logic signed [31:0] prod_r;

    assign coeff_s = coeff;
    assign prod_l  = smpl_d_l * coeff_s;
    assign prod_r  = smpl_d_r * coeff_s;

    // Q1.15 rescale, then clamp to the 16-bit signed range.
    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> 15;
        if (!s[ACC_W-1] && (|s[ACC_W-2:15])) begin
            return 16'h7FFF;
        end else if (s[ACC_W-1] && !(&s[ACC_W-2:15])) begin
            return 16'h8000;
        end else begin
            return s[15:0];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        take       = 1'b0;
        drop       = 1'b0;
        finish     = 1'b0;
        coeff_addr = '0;
        case (state)
            IDLE: begin
                if (sequencing && !seq_q) begin
                    start     = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                coeff_addr = ADR_W'((cnt >= TAPS_C) ? TAPS_M1 : cnt);
                if (!sequencing) begin
                    state_nxt = FINISH;
                end else if (cnt < TAPS_C) begin
                    take = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: sample delay aligns each sample with its ROM coefficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q    <= 1'b0;
            cnt      <= '0;
            overrun  <= 1'b0;
            mac_en_d <= 1'b0;
            smpl_d_l <= '0;
            smpl_d_r <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            lft_out  <= '0;
            rght_out <= '0;
            valid    <= 1'b0;
            tap_err  <= 1'b0;
        end else begin
            seq_q    <= sequencing;
            mac_en_d <= start | take;
            valid    <= finish;
            tap_err  <= finish && (overrun || (cnt != TAPS_C));
            if (start || take) begin
                smpl_d_l <= lft_in;
                smpl_d_r <= rght_in;
            end
            if (start) begin
                cnt     <= CNT_W'(1);
                overrun <= 1'b0;
                acc_l   <= '0;
                acc_r   <= '0;
            end else begin
                if (take) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (drop) begin
                    overrun <= 1'b1;
                end
                if ((state == ACCUM) && mac_en_d) begin
                    acc_l <= acc_l + {{(ACC_W-32){prod_l[31]}}, prod_l};
                    acc_r <= acc_r + {{(ACC_W-32){prod_r[31]}}, prod_r};
                end
            end
            if (finish) begin
                lft_out  <= sat16(acc_l);
                rght_out <= sat16(acc_r);
            end
        end
    end

endmodule

// File: tb/tb_low_freq_fir.sv
// Scoreboard bench for low_freq_fir: directed bursts push expected results,
// a negedge monitor pops and checks them whenever valid is seen.
module tb_low_freq_fir;

    localparam int TAPS = 1021;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sequencing;
    logic [15:0] lft_in;
    logic [15:0] rght_in;
    logic [9:0]  coeff_addr;
    logic [15:0] coeff = 16'h0;
    logic [15:0] lft_out;
    logic [15:0] rght_out;
    logic        valid;
    logic        tap_err;

    low_freq_fir #(.TAPS(1021), .ACC_W(42)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sequencing (sequencing),
        .lft_in     (lft_in),
        .rght_in    (rght_in),
        .coeff_addr (coeff_addr),
        .coeff      (coeff),
        .lft_out    (lft_out),
        .rght_out   (rght_out),
        .valid      (valid),
        .tap_err    (tap_err)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [0:1023];
    always @(posedge clk) coeff <= rom[coeff_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
        int err;
        int at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("lft_out", int'($signed(lft_out)), mon_e.l);
                    chk("rght_out", int'($signed(rght_out)), mon_e.r);
                    chk("tap_err", int'(tap_err), mon_e.err);
                    chk("valid_cycle", cyc, mon_e.at);
                end
            end else if (tap_err) begin
                failures++;
                $display("FAIL tap_err_without_valid actual=1 required=0 (cycle %0d)", cyc);
            end
        end
    end

    function automatic logic [15:0] smp_l(input int mode, input int i, input int imp);
        case (mode)
            0:       return 16'd100;
            1:       return (i == imp) ? 16'h4000 : 16'h0000;
            2:       return 16'h7FFF;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic logic [15:0] smp_r(input int mode);
        case (mode)
            0:       return 16'hFF9C;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            default: return 16'h8000;
        endcase
    endfunction

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 1024; i++) rom[i] = v;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Drives an n-sample burst starting at the current negedge.
    task automatic burst(input int n, input int mode, input int imp, input bit expect_out,
                         input int el, input int er, input int eerr);
        int c0;
        exp_t e;
        c0 = cyc;
        if (expect_out) begin
            e.l = el; e.r = er; e.err = eerr; e.at = c0 + n + 2;
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            sequencing = 1'b1;
            lft_in     = smp_l(mode, i, imp);
            rght_in    = smp_r(mode);
            if (expect_out && (i == 1 || i == TAPS - 1 || (i == n - 1 && n > TAPS)))
                chk("coeff_addr", int'(coeff_addr), (i < TAPS - 1) ? i : TAPS - 1);
            @(negedge clk);
        end
        sequencing = 1'b0;
        lft_in     = '0;
        rght_in    = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sequencing = 1'b0;
        lft_in     = '0;
        rght_in    = '0;
        fill(16'h0020);
        idle(3);
        chk("reset_lft_out", int'(lft_out), 0);
        chk("reset_rght_out", int'(rght_out), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_tap_err", int'(tap_err), 0);
        chk("reset_coeff_addr", int'(coeff_addr), 0);
        rst_n = 1'b1;
        idle(2);

        // DC gain
        burst(1021, 0, 0, 1'b1, 99, -100, 0);
        idle(4);

        // Alignment, impulse at first and last tap
        fill(16'h0001);
        rom[0] = 16'h7FFF;
        burst(1021, 1, 0, 1'b1, 16383, 0, 0);
        idle(4);
        fill(16'h0001);
        rom[1020] = 16'h1234;
        burst(1021, 1, 1020, 1'b1, 2330, 0, 0);
        idle(4);

        // Saturation both ways
        fill(16'h7FFF);
        burst(1021, 2, 0, 1'b1, 32767, 32767, 0);
        idle(4);
        burst(1021, 3, 0, 1'b1, -32768, -32768, 0);
        idle(4);

        // Short and overrun bursts
        fill(16'h0020);
        burst(500, 0, 0, 1'b1, 48, -49, 1);
        idle(4);
        burst(1100, 0, 0, 1'b1, 99, -100, 1);
        idle(4);

        // Reset mid-burst
        burst(300, 0, 0, 1'b0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_lft_out", int'(lft_out), 0);
        chk("midrst_rght_out", int'(rght_out), 0);
        chk("midrst_valid", int'(valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        burst(1021, 0, 0, 1'b1, 99, -100, 0);
        idle(4);

        // Back-to-back with the minimum gap
        burst(1021, 0, 0, 1'b1, 99, -100, 0);
        idle(2);
        burst(1021, 0, 0, 1'b1, 99, -100, 0);
        idle(4);

        // Burst rising during FINISH is ignored; then a single-sample burst
        burst(1021, 0, 0, 1'b1, 99, -100, 0);
        idle(1);
        burst(50, 0, 0, 1'b0, 0, 0, 0);
        idle(3);
        burst(1, 0, 0, 1'b1, 0, -1, 1);
        idle(4);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/low_freq_fir.md
# low_freq_fir

Stereo FIR filter engine for the low-frequency band of the equalizer. It consumes the sample burst the low-frequency sample queue streams out while `sequencing` is high, one left/right sample pair per clock. It fetches one coefficient per clock from an external synchronous coefficient ROM and multiply-accumulates both channels. At the end of each burst it presents one saturated 16-bit filtered sample per channel with a one-cycle valid strobe.

## Interface
- `TAPS`, 1021: expected burst length (number of taps/coefficients).
- `ACC_W`, 42: accumulator width; must hold `TAPS` full-scale 32-bit products without overflow.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sequencing` input 1: high for the duration of a sample burst from the queue.
- `lft_in` input 16: signed left sample; valid on every cycle `sequencing`=1.
- `rght_in` input 16: signed right sample; valid on every cycle `sequencing`=1.
- `coeff_addr` output 10: coefficient ROM address, driven combinationally from the tap counter.
- `coeff` input 16: signed Q1.15 coefficient; ROM returns `coeff[coeff_addr]` one clock after the address is presented.
- `lft_out` output 16: signed filtered left result; registered; holds between bursts.
- `rght_out` output 16: signed filtered right result; registered; holds between bursts.
- `valid` output 1: one-cycle pulse when `lft_out`/`rght_out` update.
- `tap_err` output 1: one-cycle pulse coincident with `valid` when the burst length was not `TAPS`.

## Operation
- States: IDLE, ACCUM, FINISH.
- `seq_q` is `sequencing` registered. A burst start is `sequencing`=1 and `seq_q`=0, detected only in IDLE.
- **IDLE to ACCUM** on burst start:
  - Clear both accumulators and set the tap counter to 1.
  - Register `lft_in`/`rght_in` into `smpl_d` and set `mac_en_d`=1.
- **ACCUM**, each cycle with `sequencing`=1:
  - Register the incoming sample pair into `smpl_d` and set `mac_en_d`=1.
  - Increment the tap counter. It saturates at `TAPS`; samples beyond `TAPS` set `mac_en_d`=0, are dropped, and mark overrun.
- **ACCUM**, whenever `mac_en_d`=1: `acc_l += smpl_d_l * coeff` and `acc_r += smpl_d_r * coeff`, with signed 16x16 products sign-extended to `ACC_W`.
- **ACCUM to FINISH** on the first cycle with `sequencing`=0. That cycle still accumulates the final delayed product.
- **FINISH**, one cycle:
  - Arithmetic-shift each accumulator right by 15 and saturate to [-32768, 32767].
  - Load `lft_out`/`rght_out` and assert `valid`.
  - Assert `tap_err` if the sample count is not equal to `TAPS` (short burst or overrun).
  - Return to IDLE.
- `coeff_addr` = tap index of the sample being presented: 0 in the burst-start cycle, k on the k-th following cycle, and held at `TAPS`-1 once saturated. In IDLE and FINISH it is 0.
- A burst whose rising edge falls during FINISH is not seen as a start in IDLE (`seq_q` already 1). It is ignored entirely: no accumulation, no output. The block rearms after `sequencing` returns low.
- A burst of length 1 is legal: 1 product, `tap_err`=1 if `TAPS` is greater than 1.

## Timing
- Reset values: state IDLE, `lft_out`=0, `rght_out`=0, `valid`=0, `tap_err`=0, accumulators 0, counter 0, `coeff_addr`=0, `seq_q`=0.
- Reset asserted mid-burst aborts immediately with no `valid`. After release, the block stays in IDLE until a fresh 0-to-1 transition of `sequencing`.
- Burst start cycle S presents sample 0 with `coeff_addr`=0. In cycle S+1, `coeff`=ROM[0] meets `smpl_d`=sample 0.
- Let F be the first cycle with `sequencing` low. The last product is accumulated at the end of F. FINISH occupies F+1, and its results are registered at the end of F+1.
- `valid`/`tap_err` are high during F+2 only. `lft_out`/`rght_out` are new from F+2 and held until the next `valid`.
- Latency for a full burst: `TAPS`+2 cycles from burst start to `valid`.
- Minimum gap between bursts for both to be processed: 2 low cycles of `sequencing`.

## Test plan
- **DC gain.** All 1021 samples `lft_in`=100 and `rght_in`=-100; all `coeff`=0x0020. Required: `lft_out`=99, `rght_out`=-100, one `valid` at start+1023, `tap_err`=0.
- **Alignment.** Impulse `lft_in`=0x4000 at sample 0 only, with `coeff[0]`=0x7FFF and other coefficients 0x0001. Required: `lft_out`=16383. Repeat with the impulse at sample 1020 and `coeff[1020]`=0x1234: `lft_out`=0x091A. `rght_out`=0 in both cases.
- **Saturation.** All samples 0x7FFF with all `coeff` 0x7FFF: `lft_out`=`rght_out`=0x7FFF. All samples 0x8000 with all `coeff` 0x7FFF: both outputs 0x8000.
- **Length errors.**
  - 500-sample burst of 100s with `coeff` 0x0020: `lft_out`=48, `valid`=1, `tap_err`=1.
  - 1100-sample burst: result equals the 1021-sample DC case, `tap_err`=1, `coeff_addr` holds 1020.
- **Reset mid-burst.** Assert `rst_n` at sample 300. Required: outputs 0, no `valid`. The next full DC burst gives `lft_out`=99.
- **Back-to-back.**
  - Two full bursts separated by 2 low cycles: two `valid` pulses with correct results.
  - A burst rising in the FINISH cycle: ignored, exactly one `valid` total.
